// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data-memory slave with wait states, byte-lane stores and extended loads
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iReq,
   input  logic        iWe,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddr,
   input  logic [31:0] iWrData,
   output logic        oBusy,
   output logic        oAck,
   output logic [31:0] oRdData,
   output logic        oErr
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t                state;
   logic [3:0]            cnt;
   logic                  req_we;
   logic [2:0]            req_f3;
   logic [ADDR_WIDTH+1:0] req_addr;
   logic [31:0]           req_wd;
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic                  cur_we;
   logic [2:0]            cur_f3;
   logic [ADDR_WIDTH+1:0] cur_addr;
   logic [31:0]           cur_wd;
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            off;
   logic [31:0]           word;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [31:0]           ld_data;
   logic [31:0]           st_data;
   logic [31:0]           st_merged;
   logic [3:0]            lanes;
   logic                  illegal;
   logic                  misaligned;
   logic                  err;
   logic                  access;
   logic                  unused_addr;
   // upper address bits are ignored so accesses wrap modulo the memory size
   assign unused_addr = ^iAddr[31:ADDR_WIDTH+2];
   // decode the active request; with no wait states the access uses the live inputs at the accept edge
   always_comb begin
      cur_we     = (state == IDLE) ? iWe : req_we;
      cur_f3     = (state == IDLE) ? iFunct3 : req_f3;
      cur_addr   = (state == IDLE) ? iAddr[ADDR_WIDTH+1:0] : req_addr;
      cur_wd     = (state == IDLE) ? iWrData : req_wd;
      idx        = cur_addr[ADDR_WIDTH+1:2];
      off        = cur_addr[1:0];
      word       = mem[idx];
      byte_sel   = word[{off, 3'b000} +: 8];
      half_sel   = off[1] ? word[31:16] : word[15:0];
      illegal    = cur_we ? (cur_f3 > 3'd2) : (cur_f3[1:0] == 2'd3 || cur_f3[2:1] == 2'b11);
      misaligned = (cur_f3[1:0] == 2'd1 && off[0]) || (cur_f3[1:0] == 2'd2 && off != 2'd0);
      err        = illegal | misaligned;
      ld_data    = (cur_f3[1:0] == 2'd0) ? {{24{~cur_f3[2] & byte_sel[7]}}, byte_sel} :
                   (cur_f3[1:0] == 2'd1) ? {{16{~cur_f3[2] & half_sel[15]}}, half_sel} : word;
      lanes      = (cur_f3[1:0] == 2'd0) ? 4'b0001 << off :
                   (cur_f3[1:0] == 2'd1) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_data    = (cur_f3[1:0] == 2'd0) ? {4{cur_wd[7:0]}} :
                   (cur_f3[1:0] == 2'd1) ? {2{cur_wd[15:0]}} : cur_wd;
      st_merged  = word;
      for (int i = 0; i < 4; i++)
         if (lanes[i]) st_merged[8*i +: 8] = st_data[8*i +: 8];
      access     = (state == WAIT && cnt == 4'd1) || (state == IDLE && iReq && WAIT_CYCLES == 0);
   end
   // request FSM with registered handshake outputs; memory commits only on the access edge
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state    <= IDLE;
         cnt      <= '0;
         req_we   <= 1'b0;
         req_f3   <= '0;
         req_addr <= '0;
         req_wd   <= '0;
         oBusy    <= 1'b0;
         oAck     <= 1'b0;
         oRdData  <= '0;
         oErr     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (iReq) begin
               req_we   <= iWe;
               req_f3   <= iFunct3;
               req_addr <= iAddr[ADDR_WIDTH+1:0];
               req_wd   <= iWrData;
               oBusy    <= 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state <= RESP;
                  oAck  <= 1'b1;
               end else begin
                  state <= WAIT;
                  cnt   <= 4'(WAIT_CYCLES);
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
                  oAck  <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               oBusy <= 1'b0;
               oAck  <= 1'b0;
               oErr  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (access) begin
            oErr <= err;
            if (!cur_we) oRdData <= err ? '0 : ld_data;
            else if (!err) mem[idx] <= st_merged;
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over three responders with 0, 1 and 3 wait states
module tb_data_mem_responder;
   typedef struct {
      logic [31:0] rd;
      logic        err;
      logic        ld;
      int          cyc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst0, rst1, rst3;
   logic        req, we;
   logic [2:0]  f3;
   logic [31:0] addr, wd;
   int          sel;
   logic        req0, req1, req3;
   logic        bu0, bu1, bu3, ak0, ak1, ak3, er0, er1, er3;
   logic [31:0] rd0, rd1, rd3;
   logic        busy, ack, err;
   logic [31:0] rd;
   exp_t        q[$];
   int          cyc = 0;
   int          acks = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          a0;
   logic        hw[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0]  hf[4]  = '{3'd2, 3'd2, 3'd3, 3'd4};
   logic [31:0] ha[4]  = '{32'h50, 32'h50, 32'h50, 32'h51};
   logic [31:0] hr[4]  = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h000000F0};
   logic        he[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign req0 = req && sel == 0;
   assign req1 = req && sel == 1;
   assign req3 = req && sel == 3;
   assign busy = sel == 0 ? bu0 : sel == 1 ? bu1 : bu3;
   assign ack  = sel == 0 ? ak0 : sel == 1 ? ak1 : ak3;
   assign err  = sel == 0 ? er0 : sel == 1 ? er1 : er3;
   assign rd   = sel == 0 ? rd0 : sel == 1 ? rd1 : rd3;
   data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) d0 (
      .iClk(clk), .iRst(rst0), .iReq(req0), .iWe(we), .iFunct3(f3), .iAddr(addr), .iWrData(wd),
      .oBusy(bu0), .oAck(ak0), .oRdData(rd0), .oErr(er0));
   data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) d1 (
      .iClk(clk), .iRst(rst1), .iReq(req1), .iWe(we), .iFunct3(f3), .iAddr(addr), .iWrData(wd),
      .oBusy(bu1), .oAck(ak1), .oRdData(rd1), .oErr(er1));
   data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) d3 (
      .iClk(clk), .iRst(rst3), .iReq(req3), .iWe(we), .iFunct3(f3), .iAddr(addr), .iWrData(wd),
      .oBusy(bu3), .oAck(ak3), .oRdData(rd3), .oErr(er3));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (sel=%0d cyc=%0d)", tag, got, want, sel, cyc);
      end
   endtask
   task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      we   = w;
      f3   = f;
      addr = a;
      wd   = d;
      req  = 1'b1;
   endtask
   task automatic expect_rsp(input logic [31:0] r, input logic e, input logic l);
      q.push_back('{r, e, l, cyc + sel});
   endtask
   task automatic wait_done();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         chk("ack_timeout", q.size(), 0);
         q.delete();
      end
   endtask
   task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] r, input logic e);
      @(negedge clk);
      drive(w, f, a, d);
      @(posedge clk);
      #1;
      expect_rsp(r, e, !w);
      req = 1'b0;
      wait_done();
   endtask
   // scoreboard: every ack must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (ack) begin
         if (q.size() == 0) chk("spurious_ack", 1, 0);
         else begin
            e = q.pop_front();
            chk("ack_cycle", cyc, e.cyc);
            chk("busy_in_resp", {31'b0, busy}, 1);
            chk("err", {31'b0, err}, {31'b0, e.err});
            if (e.ld) chk("rd_data", rd, e.rd);
            acks++;
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
      req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wd = '0; sel = 1;
      repeat (2) @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      chk("rst_busy", {29'b0, bu0, bu1, bu3}, 0);
      chk("rst_ack", {29'b0, ak0, ak1, ak3}, 0);
      chk("rst_err", {29'b0, er0, er1, er3}, 0);
      chk("rst_rd", rd0 | rd1 | rd3, 0);
      // one wait state: word, lanes, misalignment, wrap
      op(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0);
      op(0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0);
      op(1, 3'd2, 32'h20, 32'h00000000, 0, 0);
      op(1, 3'd0, 32'h23, 32'h000000F0, 0, 0);
      op(1, 3'd1, 32'h20, 32'h00008081, 0, 0);
      op(0, 3'd2, 32'h20, 0, 32'hF0008081, 0);
      op(0, 3'd0, 32'h23, 0, 32'hFFFFFFF0, 0);
      op(0, 3'd4, 32'h23, 0, 32'h000000F0, 0);
      op(0, 3'd1, 32'h20, 0, 32'hFFFF8081, 0);
      op(0, 3'd5, 32'h20, 0, 32'h00008081, 0);
      op(1, 3'd2, 32'h21, 32'h12345678, 0, 1);
      op(0, 3'd2, 32'h20, 0, 32'hF0008081, 0);
      op(0, 3'd1, 32'h23, 0, 32'h00000000, 1);
      op(1, 3'd3, 32'h20, 32'h55555555, 0, 1);
      op(0, 3'd2, 32'h20, 0, 32'hF0008081, 0);
      op(1, 3'd2, 32'h400, 32'h11112222, 0, 0);
      op(0, 3'd2, 32'h000, 0, 32'h11112222, 0);
      // zero wait states with the request held high: every other edge is an accept
      repeat (2) @(negedge clk);
      sel = 0;
      a0 = acks;
      for (int k = 0; k < 4; k++) begin
         drive(hw[k], hf[k], ha[k], 32'hCAFEF00D);
         @(posedge clk);
         #1;
         expect_rsp(hr[k], he[k], !hw[k]);
         if (k < 3) begin
            @(posedge clk);
            #1;
         end
      end
      req = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      chk("hold_acks", acks - a0, 4);
      // three wait states: reset during WAIT aborts the store
      sel = 3;
      op(1, 3'd2, 32'h40, 32'h00000000, 0, 0);
      @(negedge clk);
      drive(1, 3'd2, 32'h40, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
      req = 1'b0;
      a0 = acks;
      @(posedge clk);
      #2;
      rst3 = 1'b1;
      #1;
      chk("rst_async_busy", {31'b0, bu3}, 0);
      chk("rst_async_ack", {31'b0, ak3}, 0);
      @(negedge clk);
      rst3 = 1'b0;
      repeat (8) @(negedge clk);
      chk("no_ack_after_rst", acks - a0, 0);
      op(0, 3'd2, 32'h40, 0, 32'h00000000, 0);
      op(1, 3'd0, 32'h42, 32'h0000007E, 0, 0);
      op(0, 3'd0, 32'h42, 0, 32'h0000007E, 0);
      op(0, 3'd7, 32'h40, 0, 32'h00000000, 1);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
